alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
- Execute stage directly downstream of the instruction decoder.
- Consumes the decoder's 2-bit aluControl and flagUpdate together with the operand pair (srcB already muxed by aluSrc), and produces result and NZCV flags.
- Add completes in one cycle. Multiply (shift-add) and divide (restoring, unsigned) are iterative and multi-cycle, under a start/busy/done handshake that the control path uses to stall.

Parameters:
- WIDTH, 16, datapath width of operands and result (minimum 4).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request; operands and controls are sampled on the edge where start=1 and the unit is idle.
- aluControl  input  2  00 add, 01 mul, 10 div, 11 reserved.
- flagUpdate  input  1  1 = write flags at completion.
- srcA  input  WIDTH  operand A (multiplicand / dividend).
- srcB  input  WIDTH  operand B (multiplier / divisor).
- busy  output  1  iterative operation in progress; start is ignored while busy=1.
- done  output  1  one-cycle pulse; result is valid this cycle.
- result  output  WIDTH  registered result, held until next completion.
- flags  output  4  {N,Z,C,V}, registered, held between updates.
- divByZero  output  1  set with done when div had srcB=0; cleared on the next accepted start.

Behaviour:
- Reset: when rst_n=0 at a rising edge, busy=0, done=0, result=0, flags=0, divByZero=0, state=IDLE.
- Reset mid-operation aborts the operation. No done is produced, and result/flags return to 0.
- States:
  - IDLE, MUL, DIV, FIN.
  - Accept is start=1 while in IDLE or FIN. It latches aluControl, flagUpdate, srcA and srcB.
  - Add, reserved, or div with srcB=0 go to FIN. Mul goes to MUL and div goes to DIV, each with counter=WIDTH-1.
- MUL/DIV iteration:
  - busy=1.
  - One bit of iteration per cycle.
  - When counter=0 the unit goes to FIN; otherwise it decrements the counter.
- FIN:
  - done=1, busy=0, result and flags are written.
  - With no new start the unit goes to IDLE.
  - A start in FIN is accepted (back-to-back issue is allowed).
- Latency from the accept edge t:
  - Add, reserved and divide-by-zero: done in cycle t+1.
  - Mul and div: done in cycle t+WIDTH+1.
  - busy is high in cycles t+1 .. t+WIDTH for mul and div, and never high for the 1-cycle operations.
- Add:
  - result = (srcA+srcB) mod 2^WIDTH.
  - C = carry-out.
  - V = signed overflow (operands same sign, result sign differs).
- Mul (unsigned):
  - result = low WIDTH bits of the 2*WIDTH-bit product.
  - V = 1 if the high WIDTH bits are nonzero.
  - C = 0.
- Div (unsigned restoring):
  - result = quotient; the remainder is discarded.
  - C = 0, V = 0.
- Divide by zero: result = all ones, divByZero=1, V=1, C=0.
- Reserved (11): result = 0, and flags are not updated regardless of flagUpdate.
- Flags:
  - N = result[WIDTH-1], Z = (result==0).
  - Flags are written only in FIN, and only when the latched flagUpdate=1; otherwise they hold.
- Input changes after the accept edge have no effect on the operation in flight.
- start while busy=1 is ignored and is not queued.

Test Plan:
- Add 0x7FFF + 0x0001, flagUpdate=1 -> done at t+1, result 0x8000, flags N=1 Z=0 C=0 V=1. Follow with 0xFFFF + 0x0001 -> result 0x0000, flags N=0 Z=1 C=1 V=0.
- Mul 300 × 250 -> busy for 16 cycles, done at t+17, result 0x24F8, V=1. Then 12 × 11 -> result 0x0084, V=0.
- Div 1000 / 7 -> done at t+17, result 0x008E, flags all 0, divByZero=0. Then 5 / 0 -> done at t+1, result 0xFFFF, divByZero=1, V=1.
- Mul started, start pulsed with an add at t+5 -> add ignored, mul result correct at t+17. A start asserted in the FIN cycle is accepted, and its done arrives at the correct latency.
- rst_n=0 at t+8 of a div -> next cycle busy=0, done=0, result=0, flags=0. No done pulse appears later.
- Add 0x0001 + 0x0001 with flagUpdate=0 after a Z=1 operation -> result 0x0002, flags remain N=0 Z=1 C=1 V=0. Reserved opcode -> result 0, flags unchanged.

Source files
------------

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: one-cycle add, iterative shift-add multiply and
// restoring unsigned divide behind a start/busy/done handshake.
module alu_exec_unit #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       aluControl,
    input  logic             flagUpdate,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             divByZero
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned PW = 2 * WIDTH;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_MUL = 2'b01;
    localparam logic [1:0] OP_DIV = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             fupd;
    logic [WIDTH-1:0] opnd;   // multiplicand or divisor
    logic [PW-1:0]    prod;   // {partial high, multiplier shifting out}
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;    // dividend shifting out, quotient shifting in

    logic [WIDTH:0]   mul_sum;
    logic [PW-1:0]    mul_next;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH:0]   add_sum;
    logic             add_v;

    // Pack {N,Z,C,V} for a completed result
    function automatic logic [3:0] mk_flags(input logic [WIDTH-1:0] r,
                                            input logic c, input logic v);
        return {r[WIDTH-1], (r == '0), c, v};
    endfunction

    // One iteration of multiply / divide, plus the single-cycle add
    always_comb begin
        mul_sum   = '0;
        mul_next  = '0;
        div_shift = '0;
        div_ge    = 1'b0;
        div_diff  = '0;
        rem_next  = '0;
        quo_next  = '0;
        add_sum   = '0;
        add_v     = 1'b0;

        mul_sum   = {1'b0, prod[PW-1:WIDTH]} + (prod[0] ? {1'b0, opnd} : '0);
        mul_next  = {mul_sum, prod[WIDTH-1:1]};

        div_shift = {rem, quo[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opnd});
        div_diff  = WIDTH'(div_shift - {1'b0, opnd});
        rem_next  = div_ge ? div_diff : div_shift[WIDTH-1:0];
        quo_next  = {quo[WIDTH-2:0], div_ge};

        add_sum   = {1'b0, srcA} + {1'b0, srcB};
        add_v     = (srcA[WIDTH-1] == srcB[WIDTH-1]) &&
                    (add_sum[WIDTH-1] != srcA[WIDTH-1]);
    end

    // Control FSM with registered outputs and iteration datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            fupd      <= 1'b0;
            opnd      <= '0;
            prod      <= '0;
            rem       <= '0;
            quo       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            flags     <= '0;
            divByZero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                    if (start) begin
                        fupd      <= flagUpdate;
                        divByZero <= 1'b0;
                        case (aluControl)
                            OP_ADD: begin
                                result <= add_sum[WIDTH-1:0];
                                if (flagUpdate)
                                    flags <= mk_flags(add_sum[WIDTH-1:0], add_sum[WIDTH], add_v);
                                done  <= 1'b1;
                                state <= FIN;
                            end
                            OP_MUL: begin
                                opnd  <= srcA;
                                prod  <= {{WIDTH{1'b0}}, srcB};
                                cnt   <= CW'(WIDTH - 1);
                                busy  <= 1'b1;
                                state <= MUL;
                            end
                            OP_DIV: begin
                                if (srcB == '0) begin
                                    result    <= '1;
                                    divByZero <= 1'b1;
                                    if (flagUpdate)
                                        flags <= mk_flags('1, 1'b0, 1'b1);
                                    done  <= 1'b1;
                                    state <= FIN;
                                end else begin
                                    opnd  <= srcB;
                                    rem   <= '0;
                                    quo   <= srcA;
                                    cnt   <= CW'(WIDTH - 1);
                                    busy  <= 1'b1;
                                    state <= DIV;
                                end
                            end
                            default: begin
                                // reserved opcode: zero result, flags untouched
                                result <= '0;
                                done   <= 1'b1;
                                state  <= FIN;
                            end
                        endcase
                    end
                end
                MUL: begin
                    prod <= mul_next;
                    if (cnt == '0) begin
                        result <= mul_next[WIDTH-1:0];
                        if (fupd)
                            flags <= mk_flags(mul_next[WIDTH-1:0], 1'b0, |mul_next[PW-1:WIDTH]);
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= FIN;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                DIV: begin
                    rem <= rem_next;
                    quo <= quo_next;
                    if (cnt == '0) begin
                        result <= quo_next;
                        if (fupd)
                            flags <= mk_flags(quo_next, 1'b0, 1'b0);
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= FIN;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: vector table plus multi-cycle corner sequences.
module tb_alu_exec_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  aluControl;
    logic        flagUpdate;
    logic [15:0] srcA;
    logic [15:0] srcB;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic [3:0]  flags;
    logic        divByZero;

    int tests_run = 0;
    int tests_failed = 0;

    alu_exec_unit #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .aluControl (aluControl),
        .flagUpdate (flagUpdate),
        .srcA       (srcA),
        .srcB       (srcB),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .flags      (flags),
        .divByZero  (divByZero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic        fu;
        logic [15:0] a;
        logic [15:0] b;
        int          lat;
        logic [15:0] res;
        logic [3:0]  flg;
        logic        dbz;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Advance to the sample point just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one op; optionally pulse an add start at cycle inj (0 = none).
    // Returns at the sample point of the done cycle (or after timeout).
    task automatic run_op(input logic [1:0] op, input logic fu,
                          input logic [15:0] a, input logic [15:0] b,
                          input int inj, output int lat, output int bcnt);
        aluControl = op;
        flagUpdate = fu;
        srcA       = a;
        srcB       = b;
        start      = 1'b1;
        step();
        start      = 1'b0;
        aluControl = 2'b11;
        flagUpdate = ~fu;
        srcA       = 16'hAAAA;
        srcB       = 16'h0000;
        lat  = 0;
        bcnt = 0;
        for (int i = 1; i <= 40; i++) begin
            if (busy) bcnt++;
            if (done) begin
                lat = i;
                break;
            end
            if (i == inj) begin
                aluControl = 2'b00;
                flagUpdate = 1'b1;
                srcA       = 16'h0001;
                srcB       = 16'h0001;
                start      = 1'b1;
            end else begin
                start = 1'b0;
            end
            step();
        end
        start = 1'b0;
    endtask

    initial begin
        int lat;
        int bcnt;
        int done_cnt;

        vecs[0]  = '{2'b00, 1'b1, 16'h7FFF, 16'h0001,  1, 16'h8000, 4'b1001, 1'b0};
        vecs[1]  = '{2'b00, 1'b1, 16'hFFFF, 16'h0001,  1, 16'h0000, 4'b0110, 1'b0};
        vecs[2]  = '{2'b00, 1'b0, 16'h0001, 16'h0001,  1, 16'h0002, 4'b0110, 1'b0};
        vecs[3]  = '{2'b11, 1'b1, 16'h0005, 16'h0003,  1, 16'h0000, 4'b0110, 1'b0};
        vecs[4]  = '{2'b01, 1'b1, 16'd300,  16'd250,  17, 16'h24F8, 4'b0001, 1'b0};
        vecs[5]  = '{2'b01, 1'b1, 16'd12,   16'd11,   17, 16'h0084, 4'b0000, 1'b0};
        vecs[6]  = '{2'b10, 1'b1, 16'd1000, 16'd7,    17, 16'h008E, 4'b0000, 1'b0};
        vecs[7]  = '{2'b10, 1'b1, 16'd5,    16'd0,     1, 16'hFFFF, 4'b1001, 1'b1};
        vecs[8]  = '{2'b00, 1'b1, 16'h1234, 16'h4321,  1, 16'h5555, 4'b0000, 1'b0};
        vecs[9]  = '{2'b01, 1'b1, 16'hFFFF, 16'hFFFF, 17, 16'h0001, 4'b0001, 1'b0};
        vecs[10] = '{2'b10, 1'b1, 16'hFFFF, 16'h0001, 17, 16'hFFFF, 4'b1000, 1'b0};
        vecs[11] = '{2'b10, 1'b1, 16'd3,    16'd7,    17, 16'h0000, 4'b0100, 1'b0};
        vecs[12] = '{2'b01, 1'b0, 16'd0,    16'd5,    17, 16'h0000, 4'b0100, 1'b0};

        rst_n      = 1'b0;
        start      = 1'b0;
        aluControl = 2'b00;
        flagUpdate = 1'b0;
        srcA       = '0;
        srcB       = '0;
        repeat (3) step();
        check("rst_busy",   32'(busy), 32'd0);
        check("rst_done",   32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_flags",  32'(flags), 32'd0);
        check("rst_dbz",    32'(divByZero), 32'd0);
        rst_n = 1'b1;
        step();

        // Table of single operations, in order (flag history matters)
        for (int v = 0; v < 13; v++) begin
            run_op(vecs[v].op, vecs[v].fu, vecs[v].a, vecs[v].b, 0, lat, bcnt);
            check($sformatf("v%0d_latency", v), 32'(lat), 32'(vecs[v].lat));
            check($sformatf("v%0d_busy_cycles", v), 32'(bcnt), 32'(vecs[v].lat - 1));
            check($sformatf("v%0d_result", v), 32'(result), 32'(vecs[v].res));
            check($sformatf("v%0d_flags", v), 32'(flags), 32'(vecs[v].flg));
            check($sformatf("v%0d_dbz", v), 32'(divByZero), 32'(vecs[v].dbz));
            step();
            check($sformatf("v%0d_done_pulse", v), 32'(done), 32'd0);
        end

        // Start pulsed while a multiply is busy must be dropped
        run_op(2'b01, 1'b1, 16'd300, 16'd250, 4, lat, bcnt);
        check("ign_latency", 32'(lat), 32'd17);
        check("ign_result",  32'(result), 32'h24F8);
        check("ign_flags",   32'(flags), 32'h1);
        step();
        check("ign_no_queued_done", 32'(done), 32'd0);
        check("ign_result_held",    32'(result), 32'h24F8);

        // Back-to-back issue from the FIN cycle
        run_op(2'b01, 1'b1, 16'd12, 16'd11, 0, lat, bcnt);
        check("b2b_mul_latency", 32'(lat), 32'd17);
        check("b2b_mul_result",  32'(result), 32'h0084);
        run_op(2'b00, 1'b1, 16'd2, 16'd3, 0, lat, bcnt);
        check("b2b_add_latency", 32'(lat), 32'd1);
        check("b2b_add_result",  32'(result), 32'h0005);
        run_op(2'b10, 1'b1, 16'd1000, 16'd7, 0, lat, bcnt);
        check("b2b_div_latency", 32'(lat), 32'd17);
        check("b2b_div_result",  32'(result), 32'h008E);
        check("b2b_div_busy",    32'(bcnt), 32'd16);
        step();

        // Reset during a divide aborts it
        aluControl = 2'b10;
        flagUpdate = 1'b1;
        srcA       = 16'd1000;
        srcB       = 16'd7;
        start      = 1'b1;
        step();
        start = 1'b0;
        repeat (7) step();
        check("mid_busy_before_rst", 32'(busy), 32'd1);
        rst_n = 1'b0;
        step();
        check("abort_busy",   32'(busy), 32'd0);
        check("abort_done",   32'(done), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_flags",  32'(flags), 32'd0);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 24; i++) begin
            step();
            if (done) done_cnt++;
        end
        check("abort_no_late_done", 32'(done_cnt), 32'd0);
        check("abort_result_held",  32'(result), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
